// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// Mode constants are per-axis {active, front porch, sync, back porch}.
package vga_timing_pkg;

  localparam int CW_DEFAULT = 11;

  typedef struct packed {
    int active;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  // 800x600@72 runs at one pixel per 50 MHz clock.
  localparam axis_timing_t SVGA72_H = '{active: 800, front: 56, sync: 120, back: 64};
  localparam axis_timing_t SVGA72_V = '{active: 600, front: 37, sync: 6, back: 23};

  // 640x480@60 is intended for pix_en toggling at half rate.
  localparam axis_timing_t VGA60_H = '{active: 640, front: 16, sync: 96, back: 48};
  localparam axis_timing_t VGA60_V = '{active: 480, front: 10, sync: 2, back: 33};

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the generator (master) and the colour/pin stages (slave).
// pix_en qualifies each counter step; every output reloads on every clk50 edge, with no backpressure.
interface vga_timing_if import vga_timing_pkg::*; #(
  parameter int CW = CW_DEFAULT
);
  logic          pix_en;
  logic          hsync_out;
  logic          vsync_out;
  logic          blank_out;
  logic          active_out;
  logic [CW-1:0] x_out;
  logic [CW-1:0] y_out;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hsync_out, vsync_out, blank_out, active_out,
    output x_out, y_out, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync_out, vsync_out, blank_out, active_out,
    input  x_out, y_out, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a 0..TOTAL-1 position counter with active and sync region decode.
// wrap flags the terminal count so a following axis can step on it.
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int ACTIVE = 800,
  parameter int FRONT  = 56,
  parameter int SYNC   = 120,
  parameter int BACK   = 64,
  parameter bit POL    = 1'b1,
  parameter int CW     = CW_DEFAULT
) (
  input  logic          clk50,
  input  logic          reset,
  input  logic          step_en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          is_active,
  output logic          is_sync
);

  localparam int TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int SYNC_START = ACTIVE + FRONT;
  localparam int SYNC_END   = SYNC_START + SYNC;

  localparam logic [CW-1:0] LAST_C       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_C     = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START_C = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_END_C   = CW'(SYNC_END);

  generate
    if (FRONT < 1 || SYNC < 1 || BACK < 1 || TOTAL > (1 << CW)) begin : g_bad_timing
      $error("vga_axis_counter: zero porch/sync or total %0d exceeds %0d bits (POL=%0d)",
             TOTAL, CW, POL);
    end
  endgenerate

  assign wrap      = (count == LAST_C);
  assign is_active = (count < ACTIVE_C);
  assign is_sync   = (count >= SYNC_START_C) && (count < SYNC_END_C);

  // Terminal count goes straight back to 0, so there is no extra state past TOTAL-1.
  always_ff @(posedge clk50) begin
    if (reset) begin
      count <= '0;
    end else if (step_en) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: two axis counters plus a registered output stage.
// Outputs describe the counter position one clk50 earlier.
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int H_ACTIVE = SVGA72_H.active,
  parameter int H_FRONT  = SVGA72_H.front,
  parameter int H_SYNC   = SVGA72_H.sync,
  parameter int H_BACK   = SVGA72_H.back,
  parameter int V_ACTIVE = SVGA72_V.active,
  parameter int V_FRONT  = SVGA72_V.front,
  parameter int V_SYNC   = SVGA72_V.sync,
  parameter int V_BACK   = SVGA72_V.back,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CW       = CW_DEFAULT
) (
  input  logic         clk50,
  input  logic         reset,
  vga_timing_if.master vga
);

  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_wrap;
  logic          h_active;
  logic          h_sync;
  logic          v_wrap_unused;
  logic          v_active;
  logic          v_sync;
  logic          v_step;
  logic          in_view;
  logic          at_line_start;
  logic          at_frame_start;

  assign v_step = vga.pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_POL), .CW(CW)
  ) u_h (
    .clk50(clk50), .reset(reset), .step_en(vga.pix_en),
    .count(h_count), .wrap(h_wrap), .is_active(h_active), .is_sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_POL), .CW(CW)
  ) u_v (
    .clk50(clk50), .reset(reset), .step_en(v_step),
    .count(v_count), .wrap(v_wrap_unused), .is_active(v_active), .is_sync(v_sync)
  );

  assign in_view        = h_active & v_active;
  assign at_line_start  = vga.pix_en & (h_count == '0);
  assign at_frame_start = at_line_start & (v_count == '0);

  // Strobes stay one clk wide: h always leaves 0 on the same edge pix_en qualifies it.
  always_ff @(posedge clk50) begin
    if (reset) begin
      vga.hsync_out   <= ~H_POL;
      vga.vsync_out   <= ~V_POL;
      vga.blank_out   <= 1'b1;
      vga.active_out  <= 1'b0;
      vga.x_out       <= '0;
      vga.y_out       <= '0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.hsync_out   <= h_sync ? H_POL : ~H_POL;
      vga.vsync_out   <= v_sync ? V_POL : ~V_POL;
      vga.blank_out   <= ~in_view;
      vga.active_out  <= in_view;
      vga.x_out       <= in_view ? h_count : '0;
      vga.y_out       <= in_view ? v_count : '0;
      vga.line_start  <= at_line_start;
      vga.frame_start <= at_frame_start;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations share one stimulus stream and are
// checked every cycle against a frame-position model, plus literal timing measurements.
module tb_vga_timing_gen;

  localparam int W = 28;

  bit   clk50;
  logic reset;
  logic pix_en;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  vga_timing_if #(.CW(11)) ia ();
  vga_timing_if #(.CW(11)) ib ();
  vga_timing_if #(.CW(11)) ic ();
  vga_timing_if #(.CW(4))  id ();

  assign ia.pix_en = pix_en;
  assign ib.pix_en = pix_en;
  assign ic.pix_en = pix_en;
  assign id.pix_en = pix_en;

  vga_timing_gen u_a (.clk50(clk50), .reset(reset), .vga(ia));
  vga_timing_gen #(.H_POL(1'b0), .V_POL(1'b0)) u_b (.clk50(clk50), .reset(reset), .vga(ib));
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_c (.clk50(clk50), .reset(reset), .vga(ic));
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CW(4)
  ) u_d (.clk50(clk50), .reset(reset), .vga(id));

  // ---------------- clock ----------------
  initial forever #10 clk50 = ~clk50;

  // ---------------- model ----------------
  function automatic logic [W-1:0] pack(input bit hs, input bit vs, input bit bl, input bit ac,
                                        input bit ls, input bit fs, input int x, input int y);
    return {hs, vs, bl, ac, ls, fs, 11'(x), 11'(y)};
  endfunction

  // p is the number of qualified pixels since the frame began.
  function automatic logic [W-1:0] model(input int ha, input int hf, input int hsw, input int hb,
                                         input int va, input int vf, input int vsw, input int vb,
                                         input bit hp, input bit vp, input int p,
                                         input bit pe, input bit rst);
    int ht, h, v;
    bit act, hsy, vsy;
    if (rst) return pack(~hp, ~vp, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    ht  = ha + hf + hsw + hb;
    h   = p % ht;
    v   = p / ht;
    act = (h < ha) && (v < va);
    hsy = (h >= ha + hf) && (h < ha + hf + hsw);
    vsy = (v >= va + vf) && (v < va + vf + vsw);
    return pack(hsy ? hp : ~hp, vsy ? vp : ~vp, !act, act, pe && h == 0,
                pe && h == 0 && v == 0, act ? h : 0, act ? v : 0);
  endfunction

  function automatic int next_pos(input int p, input int frame, input bit pe, input bit rst);
    if (rst) return 0;
    return pe ? (p + 1) % frame : p;
  endfunction

  int p_a = 0;
  int p_c = 0;
  int p_d = 0;
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] exp_q_c[$];
  logic [W-1:0] exp_q_d[$];

  always @(posedge clk50) begin
    exp_q_a.push_back(model(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, p_a, pix_en, reset));
    exp_q_b.push_back(model(800, 56, 120, 64, 600, 37, 6, 23, 1'b0, 1'b0, p_a, pix_en, reset));
    exp_q_c.push_back(model(16, 2, 3, 3, 10, 2, 2, 2, 1'b1, 1'b1, p_c, pix_en, reset));
    exp_q_d.push_back(model(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, p_d, pix_en, reset));
    p_a <= next_pos(p_a, 1040 * 666, pix_en, reset);
    p_c <= next_pos(p_c, 24 * 16, pix_en, reset);
    p_d <= next_pos(p_d, 7 * 5, pix_en, reset);
    cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got hs,vs,bl,ac,ls,fs=%b x=%0d y=%0d, want %b x=%0d y=%0d",
               name, cyc, act[27:22], act[21:11], act[10:0], exp[27:22], exp[21:11], exp[10:0]);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk50) begin
    if (exp_q_a.size() > 0)
      cmp("dut_default", {ia.hsync_out, ia.vsync_out, ia.blank_out, ia.active_out,
                          ia.line_start, ia.frame_start, ia.x_out, ia.y_out}, exp_q_a.pop_front());
    if (exp_q_b.size() > 0)
      cmp("dut_lowpol", {ib.hsync_out, ib.vsync_out, ib.blank_out, ib.active_out,
                         ib.line_start, ib.frame_start, ib.x_out, ib.y_out}, exp_q_b.pop_front());
    if (exp_q_c.size() > 0)
      cmp("dut_small", {ic.hsync_out, ic.vsync_out, ic.blank_out, ic.active_out,
                        ic.line_start, ic.frame_start, ic.x_out, ic.y_out}, exp_q_c.pop_front());
    if (exp_q_d.size() > 0)
      cmp("dut_tiny", {id.hsync_out, id.vsync_out, id.blank_out, id.active_out,
                       id.line_start, id.frame_start, 7'd0, id.x_out, 7'd0, id.y_out},
          exp_q_d.pop_front());
  end

  // ---------------- timing measurements ----------------
  // probes: 0 a.line_start, 1 c.frame_start, 2 d.line_start, 3 d.frame_start, 4 a.frame_start
  logic [4:0] pr;
  logic [4:0] pr_d = '0;
  int   last_t[5] = '{-1, -1, -1, -1, -1};
  int   prev_t[5] = '{-1, -1, -1, -1, -1};
  int   wide_cnt = 0;
  int   hs_cnt_a = 0, hs_line_a = -1, hs_off_a = -1;
  int   vs_cnt_c = 0, vs_frame_c = -1;
  logic hs_d = 1'b0;

  assign pr = {ia.frame_start, id.frame_start, id.line_start, ic.frame_start, ia.line_start};

  always @(negedge clk50) begin
    for (int k = 0; k < 5; k++) begin
      if (pr[k] === 1'b1) begin
        prev_t[k] <= last_t[k];
        last_t[k] <= cyc;
      end
    end
    if (|(pr & pr_d)) wide_cnt <= wide_cnt + 1;
    pr_d <= pr;
    if (ia.line_start === 1'b1) begin
      hs_line_a <= hs_cnt_a;
      hs_cnt_a  <= int'(ia.hsync_out);
    end else begin
      hs_cnt_a  <= hs_cnt_a + int'(ia.hsync_out);
    end
    if (ia.hsync_out === 1'b1 && hs_d === 1'b0) hs_off_a <= cyc - last_t[0];
    hs_d <= ia.hsync_out;
    if (ic.frame_start === 1'b1) begin
      vs_frame_c <= vs_cnt_c;
      vs_cnt_c   <= int'(ic.vsync_out);
    end else begin
      vs_cnt_c   <= vs_cnt_c + int'(ic.vsync_out);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit pe);
    reset  = r;
    pix_en = pe;
    @(negedge clk50);
    #1;
  endtask

  // ---------------- main sequence ----------------
  int xs[5];
  int exp_x[5] = '{0, 0, 1, 1, 2};
  int px = 0;
  int ncap = 0;
  int found = 0;

  initial begin
    reset  = 1'b1;
    pix_en = 1'b1;

    // Hand-derived values that pin the model itself.
    cmp("model_origin", model(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 0, 1'b1, 1'b0),
        pack(0, 0, 0, 1, 1, 1, 0, 0));
    cmp("model_both_sync", model(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1,
                                 637 * 1040 + 856, 1'b0, 1'b0), pack(1, 1, 1, 0, 0, 0, 0, 0));
    cmp("model_last_visible", model(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1,
                                    599 * 1040 + 799, 1'b1, 1'b0), pack(0, 0, 0, 1, 0, 0, 799, 599));
    cmp("model_tiny_h3v1", model(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1, 7 + 3, 1'b1, 1'b0),
        pack(0, 0, 0, 1, 0, 0, 3, 1));

    // Reset held 3 clk with pix_en high.
    repeat (3) cycle(1'b1, 1'b1);
    check("rst_hsync", int'(ia.hsync_out), 0);
    check("rst_vsync", int'(ia.vsync_out), 0);
    check("rst_blank", int'(ia.blank_out), 1);
    check("rst_active", int'(ia.active_out), 0);
    check("rst_x", int'(ia.x_out), 0);
    check("rst_frame_start", int'(ia.frame_start), 0);
    check("rst_lowpol_hsync", int'(ib.hsync_out), 1);
    check("rst_lowpol_vsync", int'(ib.vsync_out), 1);

    cycle(1'b0, 1'b1);
    check("rel_active", int'(ia.active_out), 1);
    check("rel_x", int'(ia.x_out), 0);
    check("rel_y", int'(ia.y_out), 0);
    check("rel_frame_start", int'(ia.frame_start), 1);
    check("rel_line_start", int'(ia.line_start), 1);
    check("rel_tiny_frame_start", int'(id.frame_start), 1);

    // Full rate.
    for (int t = 0; t < 3200; t++) cycle(1'b0, 1'b1);
    check("line_period", last_t[0] - prev_t[0], 1040);
    check("hsync_width", hs_line_a, 120);
    check("hsync_offset", hs_off_a, 856);
    check("small_frame_period", last_t[1] - prev_t[1], 384);
    check("small_vsync_width", vs_frame_c, 48);
    check("tiny_line_period", last_t[2] - prev_t[2], 7);
    check("tiny_frame_period", last_t[3] - prev_t[3], 35);

    // Half rate: pix_en alternating 1,0.
    for (int t = 0; t < 6500; t++) begin
      cycle(1'b0, (t % 2) == 0);
      if (ncap == 0 && ia.line_start === 1'b1 && t > 0) begin
        xs[0] = px;
        xs[1] = int'(ia.x_out);
        ncap  = 2;
      end else if (ncap > 0 && ncap < 5) begin
        xs[ncap] = int'(ia.x_out);
        ncap++;
      end
      px = int'(ia.x_out);
    end
    check("half_line_period", last_t[0] - prev_t[0], 2080);
    check("half_hsync_width", hs_line_a, 240);
    check("half_small_frame_period", last_t[1] - prev_t[1], 768);
    check("half_tiny_line_period", last_t[2] - prev_t[2], 14);
    check("half_tiny_frame_period", last_t[3] - prev_t[3], 70);
    check("half_x_captured", ncap, 5);
    for (int k = 0; k < 5; k++) check($sformatf("half_x_step%0d", k), xs[k], exp_x[k]);

    // Random pixel enable with occasional single-clock resets.
    for (int t = 0; t < 20000; t++)
      cycle($urandom_range(0, 1999) == 0, $urandom_range(0, 2) != 0);

    // Mid-frame reset on the small mode at h=10, v=6.
    for (int t = 0; t < 500 && found == 0; t++) begin
      if (p_c == 6 * 24 + 10) found = 1;
      else cycle(1'b0, 1'b1);
    end
    check("mid_reset_reach", found, 1);
    cycle(1'b1, 1'b1);
    check("mid_rst_active", int'(ic.active_out), 0);
    check("mid_rst_blank", int'(ic.blank_out), 1);
    check("mid_rst_hsync", int'(ic.hsync_out), 0);
    check("mid_rst_xy", int'(ic.x_out) + int'(ic.y_out), 0);
    check("mid_rst_line_start", int'(ic.line_start), 0);
    check("mid_rst_lowpol_vsync", int'(ib.vsync_out), 1);
    cycle(1'b0, 1'b1);
    check("mid_rel_frame_start", int'(ic.frame_start), 1);
    check("mid_rel_active", int'(ic.active_out), 1);
    check("mid_rel_default_frame_start", int'(ia.frame_start), 1);
    for (int t = 0; t < 400; t++) cycle(1'b0, 1'b1);
    check("mid_small_frame_period", last_t[1] - prev_t[1], 384);
    check("strobe_width_violations", wide_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
